// File: rtl/f2_equiv_sweep.sv
// Exhaustive equivalence sweeper for the f2 benchmark netlist: drives all 32
// input vectors, cross-checks f2/f2_min/f2_fact and counts the f2 onset.
module f2_equiv_sweep #(
  parameter bit          STOP_ON_FAIL = 1'b0,
  parameter int unsigned EXP_ONES     = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [4:0] vec_out,
  input  logic       f2_in,
  input  logic       f2_min_in,
  input  logic       f2_fact_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] mismatch_cnt,
  output logic [5:0] ones_cnt,
  output logic       first_fail_valid,
  output logic [4:0] first_fail_vec
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t     state, state_n;
  logic [4:0] vec_n, ffvec_n;
  logic [5:0] mcnt_n, ocnt_n;
  logic       busy_n, done_n, pass_n, ffv_n;
  logic       mis, last_vec;

  assign mis      = (f2_in != f2_min_in) | (f2_in != f2_fact_in);
  assign last_vec = (vec_out == 5'd31);

  always_comb begin
    state_n = state;
    vec_n   = vec_out;
    busy_n  = busy;
    done_n  = done;
    pass_n  = pass;
    mcnt_n  = mismatch_cnt;
    ocnt_n  = ones_cnt;
    ffv_n   = first_fail_valid;
    ffvec_n = first_fail_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = SWEEP;
          vec_n   = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          mcnt_n  = '0;
          ocnt_n  = '0;
          ffv_n   = 1'b0;
          ffvec_n = '0;
        end
      end
      SWEEP: begin
        mcnt_n = mismatch_cnt + {5'd0, mis};
        ocnt_n = ones_cnt + {5'd0, f2_in};
        if (mis && !first_fail_valid) begin
          ffv_n   = 1'b1;
          ffvec_n = vec_out;
        end
        // pass uses the updated counts so it is valid on the same edge as done
        if (last_vec || (STOP_ON_FAIL && mis)) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (mcnt_n == '0) && (ocnt_n == 6'(EXP_ONES)) && last_vec;
        end else begin
          vec_n = vec_out + 5'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      ones_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      state            <= state_n;
      vec_out          <= vec_n;
      busy             <= busy_n;
      done             <= done_n;
      pass             <= pass_n;
      mismatch_cnt     <= mcnt_n;
      ones_cnt         <= ocnt_n;
      first_fail_valid <= ffv_n;
      first_fail_vec   <= ffvec_n;
    end
  end

endmodule

// File: tb/tb_f2_equiv_sweep.sv
// Directed bench for f2_equiv_sweep: golden f2 model with injectable faults on
// f2_min/f2_fact, run through full-sweep and stop-on-fail instances.
module tb_f2_equiv_sweep;

  logic       clk = 1'b0;
  logic       rst, start0, start1;
  logic       min_tie1, fact_tie0;

  logic [4:0] vec0, vec1, ffvec0, ffvec1;
  logic       f2_0, f2m_0, f2f_0, f2_1, f2m_1, f2f_1;
  logic       busy0, done0, pass0, ffv0, busy1, done1, pass1, ffv1;
  logic [5:0] mcnt0, ocnt0, mcnt1, ocnt1;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  // golden f2 over {b,d,g,f,e}
  function automatic logic golden(input logic [4:0] v);
    logic b, d, g, f, e;
    {b, d, g, f, e} = v;
    return g & (b ? (d | e) : (~d | f));
  endfunction

  assign f2_0  = golden(vec0);
  assign f2m_0 = min_tie1  ? 1'b1 : golden(vec0);
  assign f2f_0 = fact_tie0 ? 1'b0 : golden(vec0);
  assign f2_1  = golden(vec1);
  assign f2m_1 = min_tie1  ? 1'b1 : golden(vec1);
  assign f2f_1 = fact_tie0 ? 1'b0 : golden(vec1);

  f2_equiv_sweep #(.STOP_ON_FAIL(1'b0), .EXP_ONES(12)) dut (
    .clk(clk), .rst(rst), .start(start0), .vec_out(vec0),
    .f2_in(f2_0), .f2_min_in(f2m_0), .f2_fact_in(f2f_0),
    .busy(busy0), .done(done0), .pass(pass0),
    .mismatch_cnt(mcnt0), .ones_cnt(ocnt0),
    .first_fail_valid(ffv0), .first_fail_vec(ffvec0));

  f2_equiv_sweep #(.STOP_ON_FAIL(1'b1), .EXP_ONES(12)) dut_stop (
    .clk(clk), .rst(rst), .start(start1), .vec_out(vec1),
    .f2_in(f2_1), .f2_min_in(f2m_1), .f2_fact_in(f2f_1),
    .busy(busy1), .done(done1), .pass(pass1),
    .mismatch_cnt(mcnt1), .ones_cnt(ocnt1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a sweep on instance `which`; n returns edges from start edge to done.
  task automatic run_sweep(input int which, input int pulse_at, output int edges);
    bit pulsed = 1'b0;
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    edges = 0;
    while (!(which == 0 ? done0 : done1) && edges < 100) begin
      if (pulse_at >= 0 && !pulsed && (which == 0 ? vec0 : vec1) == 5'(pulse_at)) begin
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        pulsed = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      edges++;
    end
  endtask

  task automatic check_clean(input string tag);
    check({tag, "_latency"}, n, 32);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_vec"}, vec0, 31);
    check({tag, "_mcnt"}, mcnt0, 0);
    check({tag, "_ones"}, ocnt0, 12);
    check({tag, "_ffv"}, ffv0, 0);
    check({tag, "_pass"}, pass0, 1);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    min_tie1 = 1'b0; fact_tie0 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vec", vec0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_cnts", {mcnt0, ocnt0}, 0);
    check("rst_ff", {ffv0, ffvec0}, 0);
    rst = 1'b0;

    // correct netlist
    run_sweep(0, -1, n);
    check_clean("clean");

    // f2_fact tied low: every onset vector mismatches, first is vector 4
    fact_tie0 = 1'b1;
    run_sweep(0, -1, n);
    check("fact0_latency", n, 32);
    check("fact0_mcnt", mcnt0, 12);
    check("fact0_ones", ocnt0, 12);
    check("fact0_ffv", ffv0, 1);
    check("fact0_ffvec", ffvec0, 4);
    check("fact0_pass", pass0, 0);
    fact_tie0 = 1'b0;

    // f2_min tied high: every offset vector mismatches, first is vector 0
    min_tie1 = 1'b1;
    run_sweep(0, -1, n);
    check("min1_mcnt", mcnt0, 20);
    check("min1_ones", ocnt0, 12);
    check("min1_ffvec", ffvec0, 0);
    check("min1_pass", pass0, 0);
    min_tie1 = 1'b0;

    // stop-on-fail exits at vector 4
    fact_tie0 = 1'b1;
    run_sweep(1, -1, n);
    check("stop_latency", n, 5);
    check("stop_vec", vec1, 4);
    check("stop_busy", busy1, 0);
    check("stop_mcnt", mcnt1, 1);
    check("stop_ones", ocnt1, 1);
    check("stop_ffvec", ffvec1, 4);
    check("stop_pass", pass1, 0);
    fact_tie0 = 1'b0;

    // stop-on-fail instance with a correct netlist runs the full sweep
    run_sweep(1, -1, n);
    check("stop_clean_latency", n, 32);
    check("stop_clean_pass", pass1, 1);

    // reset in the middle of a sweep
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (vec0 != 5'd10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reach10", vec0, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_all_zero",
          {vec0, busy0, done0, pass0, mcnt0, ocnt0, ffv0, ffvec0}, 0);
    @(negedge clk);
    check("midrst_idle_hold", {vec0, busy0, done0}, 0);
    run_sweep(0, -1, n);
    check_clean("after_rst");

    // start during sweep ignored; start in DONE reruns identically
    run_sweep(0, 7, n);
    check_clean("ignored_start");
    run_sweep(0, -1, n);
    check_clean("rerun");

    // start and rst together: rst wins
    @(negedge clk);
    start0 = 1'b1; rst = 1'b1;
    @(negedge clk);
    start0 = 1'b0; rst = 1'b0;
    check("rst_wins", {busy0, done0, mcnt0, ocnt0}, 0);

    // start held high: done lasts one cycle and the sweep restarts
    @(negedge clk);
    start0 = 1'b1;
    n = 0;
    while (!done0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("held_latency", n, 33);
    check("held_done_pass", pass0, 1);
    @(negedge clk);
    check("held_done_pulse", done0, 0);
    check("held_restart_busy", busy0, 1);
    check("held_restart_vec", vec0, 0);
    start0 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
